// File: rtl/memory_responder_pkg.sv
// Shared types and defaults for the memory responder: FSM encoding,
// access-type codes and default bus widths.
package memory_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Codes match the bit position of the corresponding strobe in {wr, rd, rom}
    typedef enum logic [1:0] {
        ACC_ROM_RD = 2'd0,
        ACC_RAM_RD = 2'd1,
        ACC_RAM_WR = 2'd2
    } acc_t;

endpackage

// File: rtl/mem_array_1rw.sv
// Word array with one synchronous write port and one combinational read
// port; a read in the same cycle as a write to that word sees the old value.
module mem_array_1rw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Bus-side memory endpoint: captures one strobed access, waits a configurable
// number of cycles, then completes it against the ROM or RAM with a level handshake.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_address_bus,
    input  logic [DATA_W-1:0] i_data_bus,
    input  logic              i_instr_rom_read,
    input  logic              i_data_ram_read,
    input  logic              i_data_ram_write,
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ready,
    output logic              o_bus_err,
    input  logic              i_rom_load_en,
    input  logic [ADDR_W-1:0] i_rom_load_addr,
    input  logic [DATA_W-1:0] i_rom_load_data,
    output state_t            o_state
);

    // Handshake: the bus holds exactly one strobe high until o_ready is seen,
    // then drops it; o_ready stays high until the strobe is sampled low.

    state_t            state, state_nx;
    acc_t              acc_q, acc_in, acc_now;
    logic [ADDR_W-1:0] addr_q, addr_now;
    logic [DATA_W-1:0] wdata_q, wdata_now;
    logic [3:0]        cnt_q, cnt_d, wait_in;
    logic [2:0]        strb;
    logic              one_hot, illegal, capture, perform, cap_strobe;
    logic              ready_d, err_d;
    logic [DATA_W-1:0] instr_d, data_d;
    logic [DATA_W-1:0] rom_rdata, ram_rdata;
    logic              rom_we, ram_we;

    assign strb    = {i_data_ram_write, i_data_ram_read, i_instr_rom_read};
    assign one_hot = (strb == 3'b001) || (strb == 3'b010) || (strb == 3'b100);
    assign illegal = (strb != 3'b000) && !one_hot;
    assign capture = (state == IDLE) && one_hot;

    always_comb begin
        acc_in = ACC_ROM_RD;
        case (strb)
            3'b010:  acc_in = ACC_RAM_RD;
            3'b100:  acc_in = ACC_RAM_WR;
            default: acc_in = ACC_ROM_RD;
        endcase
    end

    always_comb begin
        cap_strobe = 1'b0;
        case (acc_q)
            ACC_ROM_RD: cap_strobe = i_instr_rom_read;
            ACC_RAM_RD: cap_strobe = i_data_ram_read;
            ACC_RAM_WR: cap_strobe = i_data_ram_write;
            default:    cap_strobe = 1'b0;
        endcase
    end

    assign wait_in = (acc_in == ACC_ROM_RD) ? 4'(ROM_WAIT) : 4'(RAM_WAIT);

    // A zero-wait access completes on its capture edge, so the array is
    // addressed straight from the bus while idle and from the latches otherwise.
    assign acc_now   = (state == IDLE) ? acc_in        : acc_q;
    assign addr_now  = (state == IDLE) ? i_address_bus : addr_q;
    assign wdata_now = (state == IDLE) ? i_data_bus    : wdata_q;
    assign perform   = (capture && (wait_in == 4'd0)) ||
                       ((state == WAIT) && (cnt_q == 4'd1) && cap_strobe);

    assign ram_we = perform && (acc_now == ACC_RAM_WR) && i_rst_n;
    assign rom_we = i_rom_load_en && (state == IDLE);

    mem_array_1rw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .clk   (i_clk),
        .we    (rom_we),
        .waddr (i_rom_load_addr),
        .wdata (i_rom_load_data),
        .raddr (addr_now),
        .rdata (rom_rdata)
    );

    mem_array_1rw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (addr_now),
        .wdata (wdata_now),
        .raddr (addr_now),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt_q     <= 4'd0;
            acc_q     <= ACC_ROM_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            o_ready   <= 1'b0;
            o_bus_err <= 1'b0;
            o_instr   <= '0;
            o_data    <= '0;
        end else begin
            state     <= state_nx;
            cnt_q     <= cnt_d;
            o_ready   <= ready_d;
            o_bus_err <= err_d;
            o_instr   <= instr_d;
            o_data    <= data_d;
            if (capture) begin
                acc_q   <= acc_in;
                addr_q  <= i_address_bus;
                wdata_q <= i_data_bus;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (capture) state_nx = (wait_in == 4'd0) ? RESP : WAIT;
            WAIT: begin
                if (!cap_strobe)          state_nx = IDLE;
                else if (cnt_q == 4'd1)   state_nx = RESP;
            end
            RESP: if (!cap_strobe) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = 4'd0;
        ready_d = 1'b0;
        instr_d = '0;
        data_d  = '0;
        // A persisting illegal combination alternates error and clear cycles
        err_d   = (state == IDLE) && illegal && !o_bus_err;
        if (capture) begin
            cnt_d = wait_in;
        end else if (state == WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (perform) begin
            ready_d = 1'b1;
            instr_d = (acc_now == ACC_ROM_RD) ? rom_rdata : '0;
            data_d  = (acc_now == ACC_RAM_RD) ? ram_rdata : '0;
        end else if ((state == RESP) && cap_strobe) begin
            ready_d = o_ready;
            instr_d = o_instr;
            data_d  = o_data;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: a default-wait instance and a zero-wait
// instance share one stimulus bus; read results are checked via a scoreboard queue.
module tb_memory_responder;
    import memory_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        rom_rd = 1'b0, ram_rd = 1'b0, ram_wr = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    logic [15:0] instr_a, data_a, instr_z, data_z;
    logic        ready_a, err_a, ready_z, err_z;
    state_t      state_a, state_z;

    logic [15:0] exp_q[$];
    logic [15:0] rom_m [256];
    logic [15:0] ram_m [256];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    memory_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_address_bus(addr), .i_data_bus(wdata),
        .i_instr_rom_read(rom_rd), .i_data_ram_read(ram_rd), .i_data_ram_write(ram_wr),
        .o_instr(instr_a), .o_data(data_a), .o_ready(ready_a), .o_bus_err(err_a),
        .i_rom_load_en(ld_en), .i_rom_load_addr(ld_addr), .i_rom_load_data(ld_data),
        .o_state(state_a)
    );

    memory_responder #(.ROM_WAIT(0), .RAM_WAIT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_address_bus(addr), .i_data_bus(wdata),
        .i_instr_rom_read(rom_rd), .i_data_ram_read(ram_rd), .i_data_ram_write(ram_wr),
        .o_instr(instr_z), .o_data(data_z), .o_ready(ready_z), .o_bus_err(err_z),
        .i_rom_load_en(ld_en), .i_rom_load_addr(ld_addr), .i_rom_load_data(ld_data),
        .o_state(state_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? ready_z : ready_a;
    endfunction

    function automatic logic [15:0] get_instr(input bit sel);
        return sel ? instr_z : instr_a;
    endfunction

    function automatic logic [15:0] get_data(input bit sel);
        return sel ? data_z : data_a;
    endfunction

    task automatic rom_load(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        rom_m[a] = d;
    endtask

    // One full handshake on instance sel; lat = edges from capture to o_ready
    task automatic access(input bit sel, input acc_t kind, input logic [7:0] a,
                          input logic [15:0] d, input int lat);
        int n;
        logic [15:0] e, got, other;
        if (kind == ACC_ROM_RD) exp_q.push_back(rom_m[a]);
        if (kind == ACC_RAM_RD) exp_q.push_back(ram_m[a]);
        addr = a; wdata = d;
        rom_rd = (kind == ACC_ROM_RD);
        ram_rd = (kind == ACC_RAM_RD);
        ram_wr = (kind == ACC_RAM_WR);
        n = 0;
        do begin
            tick();
            n++;
        end while (!get_rdy(sel) && n < 20);
        checks++;
        if (get_rdy(sel) !== 1'b1 || n != lat) begin
            failures++;
            $display("FAIL latency sel=%0d kind=%0d addr=%h: ready=%b after %0d edges, required 1 after %0d",
                     sel, kind, a, get_rdy(sel), n, lat);
        end
        if (kind == ACC_RAM_WR) begin
            ram_m[a] = d;
            got = get_instr(sel); other = get_data(sel); e = 16'h0;
        end else begin
            e     = exp_q.pop_front();
            got   = (kind == ACC_ROM_RD) ? get_instr(sel) : get_data(sel);
            other = (kind == ACC_ROM_RD) ? get_data(sel)  : get_instr(sel);
        end
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL read_data sel=%0d kind=%0d addr=%h: got %h, required %h", sel, kind, a, got, e);
        end
        checks++;
        if (other !== 16'h0) begin
            failures++;
            $display("FAIL other_output sel=%0d kind=%0d: got %h, required 0000", sel, kind, other);
        end
        rom_rd = 1'b0; ram_rd = 1'b0; ram_wr = 1'b0;
        tick();
        checks++;
        if (get_rdy(sel) !== 1'b0 || get_instr(sel) !== 16'h0 || get_data(sel) !== 16'h0) begin
            failures++;
            $display("FAIL release sel=%0d: ready=%b instr=%h data=%h, required 0/0000/0000",
                     sel, get_rdy(sel), get_instr(sel), get_data(sel));
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (ready_a !== 1'b0 || err_a !== 1'b0 || instr_a !== 16'h0 || data_a !== 16'h0 || state_a !== IDLE) begin
            failures++;
            $display("FAIL reset_a: ready=%b err=%b instr=%h data=%h state=%0d, required all 0",
                     ready_a, err_a, instr_a, data_a, state_a);
        end
        checks++;
        if (ready_z !== 1'b0 || err_z !== 1'b0 || instr_z !== 16'h0 || data_z !== 16'h0 || state_z !== IDLE) begin
            failures++;
            $display("FAIL reset_z: ready=%b err=%b instr=%h data=%h state=%0d, required all 0",
                     ready_z, err_z, instr_z, data_z, state_z);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rom_fetch();
        rom_load(8'h10, 16'hA5A5);
        access(0, ACC_ROM_RD, 8'h10, 16'h0, 2);
    endtask

    task automatic test_ram_write_read();
        logic [7:0]  a;
        logic [15:0] d;
        access(0, ACC_RAM_WR, 8'h3F, 16'h1234, 3);
        access(0, ACC_RAM_RD, 8'h3F, 16'h0, 3);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(8'h40, 8'h7F));
            d = 16'($urandom_range(0, 16'hFFFF));
            access(0, ACC_RAM_WR, a, d, 3);
            access(0, ACC_RAM_RD, a, 16'h0, 3);
        end
    endtask

    task automatic test_illegal();
        logic exp_err;
        addr = 8'h3F; wdata = 16'hFFFF;
        ram_rd = 1'b1; ram_wr = 1'b1;
        tick();
        ram_rd = 1'b0; ram_wr = 1'b0;
        checks++;
        if (err_a !== 1'b1 || ready_a !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse: err=%b ready=%b, required 1/0", err_a, ready_a);
        end
        tick();
        checks++;
        if (err_a !== 1'b0 || state_a !== IDLE) begin
            failures++;
            $display("FAIL illegal_clear: err=%b state=%0d, required 0/0", err_a, state_a);
        end
        rom_rd = 1'b1; ram_rd = 1'b1;
        exp_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (err_a !== exp_err || ready_a !== 1'b0) begin
                failures++;
                $display("FAIL illegal_repeat[%0d]: err=%b ready=%b, required %b/0", i, err_a, ready_a, exp_err);
            end
            exp_err = ~exp_err;
        end
        rom_rd = 1'b0; ram_rd = 1'b0;
        tick();
        tick();
        access(0, ACC_RAM_RD, 8'h3F, 16'h0, 3);
    endtask

    task automatic test_abort();
        access(0, ACC_RAM_WR, 8'h05, 16'h0000, 3);
        addr = 8'h05; wdata = 16'hBEEF; ram_wr = 1'b1;
        tick();
        ram_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ready_a !== 1'b0) begin
                failures++;
                $display("FAIL abort_ready[%0d]: got %b, required 0", i, ready_a);
            end
        end
        access(0, ACC_RAM_RD, 8'h05, 16'h0, 3);
    endtask

    task automatic test_reset_mid();
        access(0, ACC_RAM_WR, 8'h06, 16'h1111, 3);
        addr = 8'h06; wdata = 16'h7777; ram_wr = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (ready_a !== 1'b0 || data_a !== 16'h0 || instr_a !== 16'h0 || err_a !== 1'b0 || state_a !== IDLE) begin
            failures++;
            $display("FAIL reset_mid: ready=%b data=%h instr=%h err=%b state=%0d, required all 0",
                     ready_a, data_a, instr_a, err_a, state_a);
        end
        ram_wr = 1'b0;
        rst_n = 1'b1;
        tick();
        access(0, ACC_RAM_RD, 8'h06, 16'h0, 3);
    endtask

    task automatic test_zero_wait();
        logic [15:0] e;
        rom_load(8'h20, 16'h5A5A);
        access(1, ACC_ROM_RD, 8'h20, 16'h0, 1);
        addr = 8'h20; rom_rd = 1'b1;
        tick();
        ld_en = 1'b1; ld_addr = 8'h20; ld_data = 16'hFFFF;
        tick();
        ld_en = 1'b0;
        checks++;
        if (ready_z !== 1'b1 || instr_z !== 16'h5A5A) begin
            failures++;
            $display("FAIL resp_hold: ready=%b instr=%h, required 1/5a5a", ready_z, instr_z);
        end
        rom_rd = 1'b0;
        tick();
        tick();
        access(1, ACC_ROM_RD, 8'h20, 16'h0, 1);
        rom_load(8'h30, 16'h0001);
        exp_q.push_back(rom_m[8'h30]);
        addr = 8'h30; rom_rd = 1'b1;
        ld_en = 1'b1; ld_addr = 8'h30; ld_data = 16'h0002;
        tick();
        ld_en = 1'b0;
        rom_m[8'h30] = 16'h0002;
        e = exp_q.pop_front();
        checks++;
        if (ready_z !== 1'b1 || instr_z !== e) begin
            failures++;
            $display("FAIL load_capture: ready=%b instr=%h, required 1/%h", ready_z, instr_z, e);
        end
        rom_rd = 1'b0;
        tick();
        tick();
        access(1, ACC_ROM_RD, 8'h30, 16'h0, 1);
        access(1, ACC_RAM_WR, 8'h80, 16'hABCD, 1);
        access(1, ACC_RAM_RD, 8'h80, 16'h0, 1);
    endtask

    initial begin
        test_reset();
        test_rom_fetch();
        test_ram_write_read();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_zero_wait();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
Memory-side endpoint of the external bus. It accepts strobes, address and write data driven by the bus, and services them against an instruction ROM array and a data RAM array, with configurable wait states. It returns read data on o_instr or o_data together with a four-phase o_ready handshake. A side-band load port fills the ROM before program start.

Parameters:
ADDR_W, 8, address width; each array holds 2**ADDR_W words
DATA_W, 16, word width
ROM_WAIT, 1, wait cycles before a ROM read completes (0..15)
RAM_WAIT, 2, wait cycles before a RAM read or write completes (0..15)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_address_bus  in  ADDR_W  access address from the bus
i_data_bus  in  DATA_W  write data from the bus
i_instr_rom_read  in  1  ROM read strobe (level)
i_data_ram_read  in  1  RAM read strobe (level)
i_data_ram_write  in  1  RAM write strobe (level)
o_instr  out  DATA_W  ROM read data; 0 unless o_ready for a ROM read
o_data  out  DATA_W  RAM read data; 0 unless o_ready for a RAM read
o_ready  out  1  access complete; held until the strobe drops
o_bus_err  out  1  one-cycle pulse for an illegal strobe combination
i_rom_load_en  in  1  ROM load write enable
i_rom_load_addr  in  ADDR_W  ROM load address
i_rom_load_data  in  DATA_W  ROM load data

Behaviour:
- Reset is synchronous on i_clk, i_rst_n=0.
  - State goes to IDLE; wait counter is 0.
  - o_instr, o_data, o_ready and o_bus_err are all 0.
  - Any pending write is discarded.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Capture happens at edge N when exactly one strobe is high.
  - Latch the access type, i_address_bus and i_data_bus.
  - Load cnt = ROM_WAIT or RAM_WAIT.
  - If cnt = 0, go to RESP, so o_ready rises after edge N. Otherwise go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - At the edge where cnt = 1, perform the access and go to RESP.
  - Net latency: o_ready is high after edge N+WAIT.
- RESP:
  - o_ready = 1.
  - For a read, the addressed word is on o_instr or o_data; the other output is 0.
  - A RAM write is committed to the array on the RESP-entry edge, exactly once.
  - When the captured strobe is sampled low, go to IDLE; o_ready and the data outputs are 0 the next cycle.
- Abort: if the captured strobe is sampled low while in WAIT, go to IDLE with no array write and no o_ready.
- Illegal combination in IDLE (two or more strobes high):
  - No capture, stay in IDLE.
  - o_bus_err = 1 for one cycle.
  - If the combination persists, the error re-pulses every other cycle (error cycle, then a clear cycle).
- Strobes other than the captured one are ignored in WAIT and RESP. A new access needs a return to IDLE first (at least 1 idle cycle between accesses).
- Address and data are used only from the capture; bus changes after edge N have no effect.
- ROM load:
  - i_rom_load_en=1 writes the ROM word at the edge, in IDLE only.
  - While the FSM is busy, the load is ignored with no error.
  - A load and a capture in the same IDLE cycle are both performed; the capture reads the pre-load ROM word.
- RAM read-after-write to the same address in back-to-back accesses returns the new data.
- Address wrap-around does not apply; every ADDR_W value is valid.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - access type constants (ACC_ROM_RD, ACC_RAM_RD, ACC_RAM_WR)
  - ADDR_W/DATA_W defaults
- One natural sub-module, mem_array_1rw: a 1-read/1-write synchronous word array.
  - Instantiated twice: ROM (write port = load port) and RAM.
- FSM and wait counter live in the top module.

Test Plan:
- ROM fetch (ROM_WAIT=1): load ROM[0x10]=0xA5A5, then hold i_instr_rom_read=1 with addr 0x10 from edge N -> o_ready=1 and o_instr=0xA5A5 after edge N+1, o_data=0; drop strobe -> both 0 next cycle.
- RAM write/read (RAM_WAIT=2): write 0x1234 to 0x3F, handshake, then read 0x3F -> o_ready after N+2 of each access, o_data=0x1234; RAM[0x3F] written exactly once.
- Illegal strobes: ram_read=ram_write=1 for one cycle in IDLE -> o_bus_err=1 for one cycle, o_ready stays 0, RAM unchanged.
- Abort: start a RAM write of 0xBEEF to 0x05 (old 0x0000), drop the strobe after 1 cycle -> no o_ready; a later read of 0x05 returns 0x0000.
- Reset mid-access: assert i_rst_n=0 during WAIT of a RAM write -> all outputs 0 next cycle, state IDLE, write discarded.
- Zero wait (ROM_WAIT=0, RAM_WAIT=0): strobe captured at edge N -> o_ready high right after N; ROM load during RESP ignored (ROM word unchanged).
